// File: rtl/receiver.sv
// ============================================================================
// Module   : receiver
// Function : 8N1-style UART receiver (odd parity + 7 data bits, MSB first),
//            sampled on an oversample tick, with parity/framing error flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       rx,
    input  logic       rx_en,
    output logic [6:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] C_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tcnt_q;
    logic [2:0]      bcnt_q;
    logic [7:0]      shreg_q;
    logic            sync1_q;
    logic            sync2_q;
    logic [6:0]      data_q;
    logic            valid_q;
    logic            perr_q;
    logic            ferr_q;
    logic            busy_q;

    logic            rx_s;
    logic [7:0]      shreg_d;

    assign rx_s    = sync2_q;
    assign shreg_d = {shreg_q[6:0], rx_s};

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // Start detection is level-based on every clk, not gated by rx_en.
                    if (!rx_s) begin
                        tcnt_q  <= '0;
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (rx_en) begin
                        if (tcnt_q == C_HALF) begin
                            if (!rx_s) begin
                                tcnt_q  <= '0;
                                bcnt_q  <= '0;
                                state_q <= S_DATA;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (rx_en) begin
                        if (tcnt_q == C_LAST) begin
                            shreg_q <= shreg_d;
                            tcnt_q  <= '0;
                            bcnt_q  <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) begin
                                state_q <= S_STOP;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end

                S_STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is not missed.
                    if (rx_en) begin
                        if (tcnt_q == C_LAST) begin
                            data_q  <= shreg_q[6:0];
                            perr_q  <= ~(^shreg_q);
                            ferr_q  <= ~rx_s;
                            valid_q <= 1'b1;
                            tcnt_q  <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire
